// File: rtl/sme_pkg.sv
// Shared constants and FSM state type for the string-matching engine.
package sme_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        LD_STR,
        LD_PAT,
        SEARCH,
        DONE
    } state_t;

endpackage

// File: rtl/sme_window_cmp.sv
// Combinational test of one start position s: compares the pattern body against the
// string window str[s-1 .. s+PAT_MAX] and applies the '^'/'$' word-boundary rules.
module sme_window_cmp
    import sme_pkg::*;
#(
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned PLEN_W  = 4
) (
    input  logic [PAT_MAX+1:0][7:0] win,     // win[0] = str[s-1], win[1+j] = str[s+j]
    input  logic [PAT_MAX-1:0][7:0] pat,
    input  logic                    caret,
    input  logic                    dollar,
    input  logic [PLEN_W-1:0]       k,
    input  logic [CNT_W-1:0]        slen,
    input  logic [CNT_W-1:0]        s,
    output logic                    hit
);

    logic [PAT_MAX-1:0][7:0] body;
    logic [CNT_W:0]          end_pos;
    logic                    body_ok;
    logic                    pos_ok;
    logic                    pre_ok;
    logic                    post_ok;

    // Drop the leading '^' so body[j] lines up with str[s+j]; evaluate all rules
    always_comb begin
        body    = caret ? (pat >> 8) : pat;
        end_pos = {1'b0, s} + (CNT_W + 1)'(k);
        pos_ok  = (k != '0) && (end_pos <= {1'b0, slen});
        body_ok = 1'b1;
        for (int j = 0; j < PAT_MAX; j++) begin
            if ((j < int'(k)) && (body[j] != CH_DOT) && (body[j] != win[j+1])) begin
                body_ok = 1'b0;
            end
        end
        pre_ok  = !caret || (s == '0) || (win[0] == CH_SPACE);
        post_ok = !dollar || (end_pos == {1'b0, slen}) || (win[int'(k)+1] == CH_SPACE);
        hit     = pos_ok && body_ok && pre_ok && post_ok;
    end

endmodule

// File: rtl/sme_param_search.sv
// Parametrised string-matching engine: holds one string, searches each loaded pattern
// against it one start position per cycle, reports first/last match index and match count.
module sme_param_search
    import sme_pkg::*;
#(
    parameter int unsigned  STR_MAX = 32,
    parameter int unsigned  PAT_MAX = 8,
    localparam int unsigned IDX_W   = $clog2(STR_MAX),
    localparam int unsigned CNT_W   = $clog2(STR_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    input  logic             isstring,
    input  logic             ispattern,
    input  logic             find_last,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned PLEN_W = $clog2(PAT_MAX + 1);
    localparam int unsigned PIDX_W = $clog2(PAT_MAX);

    state_t                  state_q, state_d;
    logic [7:0]              str_q [STR_MAX];
    logic [CNT_W-1:0]        slen_q;
    logic [PAT_MAX-1:0][7:0] pat_q;
    logic [PLEN_W-1:0]       plen_q;
    logic                    find_last_q;
    logic [CNT_W-1:0]        s_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    found_q, found_d;
    logic [IDX_W-1:0]        first_q, first_d, last_q, last_d;

    logic                    str_wr, pat_wr;
    logic [PIDX_W-1:0]       last_pi;
    logic                    caret, dollar, no_pos, scan_last, hit;
    logic [PLEN_W-1:0]       k;
    logic [PAT_MAX+1:0][7:0] win;

    // Anchor decode, body length and end-of-scan detection
    always_comb begin
        str_wr    = isstring && ((state_q == IDLE) || (state_q == LD_STR));
        pat_wr    = ispattern && (((state_q == IDLE) && !isstring) || (state_q == LD_PAT));
        last_pi   = (plen_q == '0) ? '0 : PIDX_W'(plen_q - 1'b1);
        caret     = (plen_q != '0) && (pat_q[0] == CH_CARET);
        dollar    = (plen_q > PLEN_W'(caret)) && (pat_q[last_pi] == CH_DOLLAR);
        k         = plen_q - PLEN_W'(caret) - PLEN_W'(dollar);
        no_pos    = (k == '0) || (CNT_W'(k) > slen_q);
        scan_last = no_pos || (s_q == slen_q - CNT_W'(k));
    end

    // String window around the current start position; off-string slots read as NUL
    always_comb begin
        for (int i = 0; i < PAT_MAX + 2; i++) begin
            int widx;
            widx = int'(s_q) + i - 1;
            if ((widx >= 0) && (widx < int'(STR_MAX))) begin
                win[i] = str_q[widx[IDX_W-1:0]];
            end else begin
                win[i] = 8'h00;
            end
        end
    end

    sme_window_cmp #(
        .PAT_MAX (PAT_MAX),
        .CNT_W   (CNT_W),
        .PLEN_W  (PLEN_W)
    ) u_cmp (
        .win    (win),
        .pat    (pat_q),
        .caret  (caret),
        .dollar (dollar),
        .k      (k),
        .slen   (slen_q),
        .s      (s_q),
        .hit    (hit)
    );

    // Next-state logic; isstring takes priority over ispattern in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (isstring) state_d = LD_STR;
                     else if (ispattern) state_d = LD_PAT;
            LD_STR:  if (!isstring) state_d = IDLE;
            LD_PAT:  if (!ispattern) state_d = SEARCH;
            SEARCH:  if (scan_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Running result including the position being tested this cycle
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(hit);
        found_d = found_q || hit;
        first_d = (hit && !found_q) ? s_q[IDX_W-1:0] : first_q;
        last_d  = hit ? s_q[IDX_W-1:0] : last_q;
    end

    // FSM state and buffer lengths; a load from IDLE restarts at index 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            slen_q      <= '0;
            plen_q      <= '0;
            find_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (str_wr) begin
                if (state_q == IDLE) slen_q <= CNT_W'(1);
                else if (slen_q < CNT_W'(STR_MAX)) slen_q <= slen_q + 1'b1;
            end
            if (pat_wr) begin
                if (state_q == IDLE) begin
                    plen_q      <= PLEN_W'(1);
                    find_last_q <= find_last;
                end else if (plen_q < PLEN_W'(PAT_MAX)) begin
                    plen_q <= plen_q + 1'b1;
                end
            end
        end
    end

    // Character storage; contents are only meaningful below slen/plen, so no reset
    always_ff @(posedge clk) begin
        if (str_wr) begin
            if (state_q == IDLE) str_q[0] <= chardata;
            else if (slen_q < CNT_W'(STR_MAX)) str_q[slen_q[IDX_W-1:0]] <= chardata;
        end
        if (pat_wr) begin
            if (state_q == IDLE) pat_q[0] <= chardata;
            else if (plen_q < PLEN_W'(PAT_MAX)) pat_q[plen_q[PIDX_W-1:0]] <= chardata;
        end
    end

    // Scan counter, accumulators and registered result with one-cycle valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q         <= '0;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            first_q     <= '0;
            last_q      <= '0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            match_count <= '0;
        end else begin
            valid <= 1'b0;
            if ((state_q == LD_PAT) && !ispattern) begin
                s_q     <= '0;
                cnt_q   <= '0;
                found_q <= 1'b0;
            end else if (state_q == SEARCH) begin
                s_q     <= s_q + 1'b1;
                cnt_q   <= cnt_d;
                found_q <= found_d;
                first_q <= first_d;
                last_q  <= last_d;
                if (scan_last) begin
                    valid       <= 1'b1;
                    match       <= found_d;
                    match_index <= found_d ? (find_last_q ? last_d : first_d) : '0;
                    match_count <= cnt_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_sme_param_search.sv
// Self-checking bench for sme_param_search: directed cases plus random strings/patterns
// checked against a loop-based reference matcher.
module tb_sme_param_search;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;

    typedef byte unsigned bq_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chardata;
    logic       isstring, ispattern, find_last;
    logic       valid, match;
    logic [4:0] match_index;
    logic [5:0] match_count;

    int   vectors = 0;
    int   miscompares = 0;
    bq_t  cur_str;

    sme_param_search #(
        .STR_MAX (STR_MAX),
        .PAT_MAX (PAT_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .find_last   (find_last),
        .valid       (valid),
        .match       (match),
        .match_index (match_index),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void str2q(input string s, output bq_t q);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    // Reference matcher: truncate, strip anchors, try every start position
    function automatic void model(input bq_t s_in, input bq_t p_in, input bit fl,
                                  output bit m, output int idx, output int cnt,
                                  output int lat);
        bq_t s, p, body;
        bit  car, dol, ok;
        int  n, k;
        s = {};
        p = {};
        body = {};
        for (int i = 0; i < s_in.size() && i < STR_MAX; i++) s.push_back(s_in[i]);
        for (int i = 0; i < p_in.size() && i < PAT_MAX; i++) p.push_back(p_in[i]);
        car = (p.size() > 0) && (p[0] == 8'h5E);
        dol = (p.size() > int'(car)) && (p[p.size()-1] == 8'h24);
        for (int i = int'(car); i < p.size() - int'(dol); i++) body.push_back(p[i]);
        k = body.size();
        n = s.size();
        m = 0; idx = 0; cnt = 0;
        lat = (k > 0 && k <= n) ? n - k + 2 : 2;
        if (k > 0 && k <= n) begin
            for (int st = 0; st <= n - k; st++) begin
                ok = 1;
                for (int j = 0; j < k; j++)
                    if (body[j] != 8'h2E && body[j] != s[st+j]) ok = 0;
                if (car && st != 0 && s[st-1] != 8'h20) ok = 0;
                if (dol && st + k != n && s[st+k] != 8'h20) ok = 0;
                if (ok) begin
                    cnt++;
                    if (!m || fl) idx = st;
                    m = 1;
                end
            end
        end
    endfunction

    task automatic load_str(input bq_t q);
        foreach (q[i]) begin
            @(negedge clk);
            chardata = q[i];
            isstring = 1'b1;
        end
        @(negedge clk);
        isstring = 1'b0;
        cur_str  = q;
    endtask

    task automatic send_pat(input bq_t q, input bit fl);
        foreach (q[i]) begin
            @(negedge clk);
            chardata  = q[i];
            ispattern = 1'b1;
            find_last = fl;
        end
        @(negedge clk);
        ispattern = 1'b0;
    endtask

    // Send a pattern, wait (bounded) for valid, check latency, result and pulse width
    task automatic search(input string tag, input bq_t p, input bit fl);
        bit e_m;
        int e_idx, e_cnt, e_lat, n;
        model(cur_str, p, fl, e_m, e_idx, e_cnt, e_lat);
        send_pat(p, fl);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (valid !== 1'b1 && n < 80);
        chk({tag, ".latency"}, n, e_lat);
        chk({tag, ".match"}, match, e_m);
        chk({tag, ".index"}, match_index, e_idx);
        chk({tag, ".count"}, match_count, e_cnt);
        @(negedge clk);
        chk({tag, ".pulse"}, valid, 1'b0);
    endtask

    task automatic search_s(input string tag, input string p, input bit fl);
        bq_t q;
        str2q(p, q);
        search(tag, q, fl);
    endtask

    initial begin
        bq_t q, p;
        int  pulses;

        reset = 1'b1;
        chardata = 8'h00; isstring = 1'b0; ispattern = 1'b0; find_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.valid", valid, 1'b0);
        chk("rst.match", match, 1'b0);
        chk("rst.index", match_index, 0);
        chk("rst.count", match_count, 0);
        reset = 1'b0;
        @(negedge clk);

        str2q("hello world", q);
        load_str(q);
        search_s("t1.wor", "wor", 1'b0);
        search_s("t2.o_last", "o", 1'b1);
        search_s("t2.o_first", "o", 1'b0);
        search_s("t3.caret_wor", "^wor", 1'b0);
        search_s("t3.o_dollar", "o$", 1'b0);
        search_s("t3.l_dot_o", "l.o", 1'b0);
        search_s("t3.caret_o", "^o", 1'b0);
        search_s("t3.d_dollar", "d$", 1'b1);

        str2q("ab", q);
        load_str(q);
        search_s("t4.too_long", "abc", 1'b0);
        search_s("t4.anchors", "^$", 1'b0);

        q = {};
        repeat (40) q.push_back(8'h61);
        load_str(q);
        search_s("t5.aa", "aa", 1'b0);
        search_s("t5.aa_last", "aa", 1'b1);
        search_s("t5.pat_trunc", "aaaaaaaabb", 1'b0);

        // Reset in the middle of a long scan
        q = {};
        repeat (30) q.push_back(8'h61);
        load_str(q);
        str2q("a", p);
        send_pat(p, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6.rst_match", match, 1'b0);
        chk("t6.rst_count", match_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cur_str = {};
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid === 1'b1) pulses++;
        end
        chk("t6.no_valid", pulses, 0);
        search_s("t6.str_gone", "a", 1'b0);
        str2q("ab ba ab", q);
        load_str(q);
        search_s("t6.reload", "ab$", 1'b1);

        // Random strings over a small alphabet, several patterns per string
        for (int it = 0; it < 32; it++) begin
            if (it % 4 == 0) begin
                q = {};
                repeat ($urandom_range(1, 40)) begin
                    case ($urandom_range(0, 3))
                        0, 1:    q.push_back(8'h61);
                        2:       q.push_back(8'h62);
                        default: q.push_back(8'h20);
                    endcase
                end
                load_str(q);
            end
            p = {};
            if ($urandom_range(0, 2) == 0) p.push_back(8'h5E);
            repeat ($urandom_range(1, 9)) begin
                case ($urandom_range(0, 4))
                    0, 1:    p.push_back(8'h61);
                    2, 3:    p.push_back(8'h62);
                    default: p.push_back(8'h2E);
                endcase
            end
            if ($urandom_range(0, 2) == 0) p.push_back(8'h24);
            search($sformatf("rnd%0d", it), p, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
